// File: rtl/soc_system_pio_edge_in_pkg.sv
// Shared definitions for the edge-capturing PIO input block: register map,
// edge-type encodings and the per-bit edge detector.
package soc_system_pio_edge_in_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Warm-up count at which edge detection is allowed.
    localparam logic [1:0] WARM_DONE = 2'd3;

    function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
        case (edge_type)
            EDGE_RISING:  return cur & ~prev;
            EDGE_FALLING: return ~cur & prev;
            default:      return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/soc_system_pio_sync.sv
// Two-flop synchronizer for asynchronous external inputs, one chain per bit.
module soc_system_pio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/soc_system_pio_edge_in.sv
// Avalon-MM PIO input port with synchronized edge capture, W1C capture
// register, interrupt mask and level interrupt.
module soc_system_pio_edge_in
    import soc_system_pio_edge_in_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_TYPE  = 0,
    parameter int IRQ_EN     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] s2;
    logic [DATA_WIDTH-1:0] s3;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecap;
    logic [DATA_WIDTH-1:0] edges;
    logic [DATA_WIDTH-1:0] clr;
    logic [1:0]            warm;
    logic [31:0]           rd_next;
    logic                  unused_wdata;

    soc_system_pio_sync #(.WIDTH(DATA_WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (s2)
    );

    // Bits of writedata above DATA_WIDTH carry no meaning for this block.
    assign unused_wdata = ^(writedata >> DATA_WIDTH);

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        edges = '0;
        if (warm == WARM_DONE) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                edges[i] = edge_hit(EDGE_TYPE, s2[i], s3[i]);
            end
        end
    end

    assign clr = (write && reg_addr_e'(address) == ADDR_EDGECAP) ? writedata[DATA_WIDTH-1:0] : '0;

    always_comb begin
        rd_next = '0;
        case (reg_addr_e'(address))
            ADDR_DATA:    rd_next[DATA_WIDTH-1:0] = s2;
            ADDR_IRQMASK: rd_next[DATA_WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[DATA_WIDTH-1:0] = edgecap;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3       <= '0;
            warm     <= '0;
            irqmask  <= '0;
            edgecap  <= '0;
            readdata <= '0;
        end else begin
            s3       <= s2;
            readdata <= rd_next;
            if (warm != WARM_DONE) begin
                warm <= warm + 2'd1;
            end
            if (IRQ_EN != 0 && write && reg_addr_e'(address) == ADDR_IRQMASK) begin
                irqmask <= writedata[DATA_WIDTH-1:0];
            end
            // A fresh edge overrides a simultaneous clear of the same bit.
            edgecap <= (edgecap & ~clr) | edges;
        end
    end

    generate
        if (IRQ_EN != 0) begin : g_irq
            assign irq = |(edgecap & irqmask);
        end else begin : g_no_irq
            assign irq = 1'b0;
        end
    endgenerate

endmodule
